// File: rtl/hls_macc_sched_if.sv
// Requester, response and macc-core signals of the shared macc scheduler, bundled as one port.
// The slave view is the scheduler; the master view is the requesters and core that surround it.
interface hls_macc_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*10*DW-1:0]  req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IW-1:0]             rsp_id;
  logic [4*DW-1:0]           rsp_data;
  logic                      rsp_err;
  logic                      busy;
  logic                      macc_start;
  logic                      macc_idle;
  logic                      macc_done;
  logic [10*DW-1:0]          macc_in;
  logic [DW-1:0]             macc_out1;
  logic [DW-1:0]             macc_out2;
  logic [DW-1:0]             macc_out3;
  logic [2:0]                macc_vld;
  logic [DW-1:0]             macc_ret;

  modport slave (
    input  req_valid, req_data, rsp_ready,
    input  macc_idle, macc_done, macc_out1, macc_out2, macc_out3, macc_vld, macc_ret,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, macc_start, macc_in
  );

  modport master (
    output req_valid, req_data, rsp_ready,
    output macc_idle, macc_done, macc_out1, macc_out2, macc_out3, macc_vld, macc_ret,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, macc_start, macc_in
  );
endinterface

// File: rtl/hls_macc_sched.sv
// Round-robin share of one macc core: grant T, ap_start T+1, response the cycle after ap_done (watchdog abort).
// One run in flight; the response is held until rsp_ready, and no grant is issued while busy or core not idle.
module hls_macc_sched #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  hls_macc_sched_if.slave    bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int OW = 10 * DW;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [IW:0]   NREQ    = (IW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [WW-1:0]        wd_cnt;
  logic [NUM_REQ-1:0]   rot;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;
  logic [IW-1:0]        gnt_idx;
  logic [IW-1:0]        nxt_ptr;
  logic                 gnt_any;
  logic [NUM_REQ-1:0]   req_rdy;
  logic [OW-1:0]        gnt_dat;
  logic [OW-1:0]        macc_in;
  logic [IW-1:0]        rsp_id;
  logic [4*DW-1:0]      rsp_data;
  logic                 rsp_valid;
  logic                 rsp_err;
  logic                 macc_start;
  logic                 busy;

  // Rotate so rr_ptr sits at bit 0; the lowest set bit of rot is the next requester in turn.
  always_comb begin
    rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[IW'(k)]) off = IW'(k);
    end
    sum     = {1'b0, rr_ptr} + {1'b0, off};
    gnt_idx = (sum >= NREQ) ? IW'(sum - NREQ) : IW'(sum);
    nxt_ptr = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    gnt_any = (state == IDLE) && bus.macc_idle && (|bus.req_valid) && !ap_rst;
    gnt_dat = '0;
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        gnt_dat    = bus.req_data[i*OW +: OW];
        req_rdy[i] = gnt_any;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      macc_in    <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      macc_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            macc_in    <= gnt_dat;
            rsp_id     <= gnt_idx;
            rr_ptr     <= nxt_ptr;
            macc_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          macc_start <= 1'b0;
          wd_cnt     <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A done arriving on the last watchdog cycle still counts as a completed run.
          if (bus.macc_done) begin
            rsp_err   <= ~&bus.macc_vld;
            rsp_data  <= (&bus.macc_vld) ?
                         {bus.macc_ret, bus.macc_out3, bus.macc_out2, bus.macc_out1} : '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.macc_in    = macc_in;
  assign bus.macc_start = macc_start;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_err    = rsp_err;
  assign bus.busy       = busy;
endmodule
